gate_test_sequencer: RTL and testbench

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

---
 rtl/gate_test_sequencer.sv | 129 ++++++++++++
 tb/tb_gate_test_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Gate-level truth-table sequencer: evaluates one of eight logic ops over all
// eight operand combos and stores each op's 8-bit truth table for readback.
//
// state | meaning
// IDLE  | waiting for a start rising edge
// EVAL  | one op bit per cycle, combo 0..7
// LATCH | commit the assembled byte to table[cur_op]
// NEXT  | advance to the next op (sweep) or finish
// DONE  | run complete, waiting for start to drop
module gate_test_sequencer (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        LATCH = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic [2:0] op_sel;
    logic       out_sel;

    assign clk     = io_in[0];
    assign reset   = io_in[1];
    assign start   = io_in[2];
    assign mode    = io_in[3];
    assign op_sel  = io_in[6:4];
    assign out_sel = io_in[7];

    state_t     state;
    logic [2:0] combo;
    logic [2:0] cur_op;
    logic       q;
    logic       busy;
    logic       done;
    logic       start_d;
    logic       armed;
    logic       mode_r;
    logic [7:0] asm_byte;
    logic [7:0] table_mem [8];

    function automatic logic op_bit(input logic [2:0] op, input logic [2:0] k, input logic q_in);
        logic a, b, c;
        a = k[0];
        b = k[1];
        c = k[2];
        case (op)
            3'd0:    op_bit = a & b;
            3'd1:    op_bit = a | b;
            3'd2:    op_bit = a ^ b;
            3'd3:    op_bit = ~(a & b);
            3'd4:    op_bit = ~a;
            3'd5:    op_bit = a;
            3'd6:    op_bit = c ? b : a;
            default: op_bit = q_in;
        endcase
    endfunction

    // armed stays low after reset until start is seen low, so a start held
    // through reset release cannot look like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            combo    <= 3'd0;
            cur_op   <= 3'd0;
            q        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            start_d  <= 1'b0;
            armed    <= 1'b0;
            mode_r   <= 1'b0;
            asm_byte <= 8'h00;
            for (int i = 0; i < 8; i++) table_mem[i] <= 8'h00;
        end else begin
            start_d <= start;
            if (!start) armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (start && !start_d && armed) begin
                        mode_r <= mode;
                        cur_op <= mode ? 3'd0 : op_sel;
                        combo  <= 3'd0;
                        q      <= 1'b0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    // The DFF op reports q from before this cycle's update.
                    asm_byte[combo] <= op_bit(cur_op, combo, q);
                    q               <= combo[0];
                    combo           <= combo + 3'd1;
                    if (combo == 3'd7) state <= LATCH;
                end
                LATCH: begin
                    table_mem[cur_op] <= asm_byte;
                    state             <= NEXT;
                end
                NEXT: begin
                    if (mode_r && cur_op != 3'd7) begin
                        cur_op <= cur_op + 3'd1;
                        combo  <= 3'd0;
                        q      <= 1'b0;
                        state  <= EVAL;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_out = out_sel ? {busy, done, cur_op, combo} : table_mem[op_sel];

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench for gate_test_sequencer: directed runs push expected
// io_out values; a negedge monitor pops and compares them.
module tb_gate_test_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] op_sel = 3'd0;
    logic       out_sel = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q  [$];
    string      name_q [$];

    assign io_in = {out_sel, op_sel, mode, start, reset, clk};

    gate_test_sequencer dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [7:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_checks++;
            if (io_out === e) n_pass++;
            else $display("FAIL %s: io_out=%02h expected %02h", n, io_out, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_out(input logic os, input logic [2:0] sel, input logic [7:0] e, input string name);
        out_sel = os;
        op_sel  = sel;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] sweep_tbl [8];

    initial begin
        sweep_tbl[0] = 8'h88; sweep_tbl[1] = 8'hEE; sweep_tbl[2] = 8'h66; sweep_tbl[3] = 8'h77;
        sweep_tbl[4] = 8'h55; sweep_tbl[5] = 8'hAA; sweep_tbl[6] = 8'hCA; sweep_tbl[7] = 8'h54;

        // reset state
        tick_n(2);
        reset = 1'b0;
        expect_out(1'b0, 3'd0, 8'h00, "reset_result");
        expect_out(1'b1, 3'd0, 8'h00, "reset_status");

        // single run of op 0, start held high throughout
        mode = 1'b0; op_sel = 3'd0; start = 1'b1;
        tick();
        tick_n(3);
        expect_out(1'b1, 3'd0, 8'h83, "single_eval_combo3");
        tick_n(6);
        expect_out(1'b1, 3'd0, 8'h80, "single_cycle10_busy");
        tick();
        expect_out(1'b1, 3'd0, 8'h40, "single_cycle11_done");
        expect_out(1'b0, 3'd0, 8'h88, "single_table0");
        tick_n(3);
        expect_out(1'b1, 3'd0, 8'h40, "done_held_start");
        start = 1'b0;
        tick();
        expect_out(1'b1, 3'd0, 8'h40, "idle_done_kept");

        // sweep with a second start edge and a mode change mid-run
        mode = 1'b1; start = 1'b1;
        tick();
        expect_out(1'b1, 3'd0, 8'h80, "sweep_start_done_clr");
        tick_n(20);
        expect_out(1'b1, 3'd0, 8'h90, "sweep_op2_entry");
        start = 1'b0;
        tick();
        start = 1'b1; mode = 1'b0;
        tick();
        tick_n(57);
        expect_out(1'b1, 3'd0, 8'hB8, "sweep_cycle80_busy");
        tick();
        expect_out(1'b1, 3'd0, 8'h78, "sweep_cycle81_done");
        for (int i = 0; i < 8; i++)
            expect_out(1'b0, 3'(i), sweep_tbl[i], $sformatf("sweep_table%0d", i));
        expect_out(1'b1, 3'd0, 8'h78, "sweep_no_restart");

        // reset at cycle 40 of a sweep, start held high through release
        start = 1'b0;
        tick();
        mode = 1'b1; start = 1'b1;
        tick();
        tick_n(39);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out(1'b1, 3'd0, 8'h00, "midreset_status");
        for (int i = 0; i < 8; i++)
            expect_out(1'b0, 3'(i), 8'h00, $sformatf("midreset_table%0d", i));
        tick_n(3);
        expect_out(1'b1, 3'd0, 8'h00, "midreset_held_start");

        // single run of op 6 with op_sel and mode changed mid-run
        start = 1'b0;
        tick();
        op_sel = 3'd6; mode = 1'b0; start = 1'b1;
        tick();
        tick_n(2);
        op_sel = 3'd3; mode = 1'b1;
        tick_n(8);
        expect_out(1'b1, 3'd3, 8'h70, "op6_done_status");
        expect_out(1'b0, 3'd6, 8'hCA, "op6_table6");
        expect_out(1'b0, 3'd3, 8'h00, "op6_table3_kept");
        expect_out(1'b0, 3'd0, 8'h00, "op6_table0_kept");

        // fresh start after DONE clears done and launches a new run
        start = 1'b0;
        tick();
        expect_out(1'b1, 3'd0, 8'h70, "idle_after_op6");
        mode = 1'b0; op_sel = 3'd1; start = 1'b1;
        tick();
        expect_out(1'b1, 3'd1, 8'h88, "rerun_busy_done_clr");
        tick_n(10);
        expect_out(1'b1, 3'd1, 8'h48, "rerun_done");
        expect_out(1'b0, 3'd1, 8'hEE, "rerun_table1");
        expect_out(1'b0, 3'd6, 8'hCA, "rerun_table6_kept");

        tick_n(2);
        if (exp_q.size() != 0) begin
            n_checks += exp_q.size();
            $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
